// File: rtl/fb_word_fetcher.sv
// fb_word_fetcher
//   Frame-buffer read engine. On a start pulse it walks memory addresses
//   0..FRAME_WORDS-1 into a synchronous-read memory, absorbs the one-cycle
//   read latency, buffers the returned words in a small FIFO and streams
//   them downstream over valid/ready with an end-of-frame tag.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       single-cycle frame request (ignored while busy)
//   busy        frame in progress
//   frame_done  one-cycle pulse after the last word is accepted
//   mem_addr    registered read address to memory
//   mem_data    memory read data (valid the cycle after mem_addr is sampled)
//   out_data    FIFO head word
//   out_valid   FIFO non-empty
//   out_ready   downstream accept
//   out_last    head word belongs to address FRAME_WORDS-1
module fb_word_fetcher #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32,
    parameter int FRAME_WORDS = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W:0]    DEPTH_V   = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_rd_pending;
    logic              r_pending_last;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_out_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic              r_fifo_last [FIFO_DEPTH];

    logic [CNT_W:0]    w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_last_pop;
    logic [CNT_W-1:0]  w_count_next;

    // Issue/push/pop decisions and next FIFO occupancy.
    always_comb begin
        w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rd_pending};
        // In-flight read counts against free space so the push can never overflow.
        w_issue      = (r_state == ST_FETCH) && (w_occupancy < DEPTH_V);
        w_push       = r_rd_pending;
        w_pop        = r_out_valid && out_ready;
        w_last_pop   = w_pop && r_fifo_last[r_rd_ptr];
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Frame sequencer: address generation, read tracking, busy/frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_mem_addr     <= {ADDR_W{1'b0}};
            r_rd_pending   <= 1'b0;
            r_pending_last <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mem_addr     <= {ADDR_W{1'b0}};
                    r_rd_pending   <= 1'b0;
                    r_pending_last <= 1'b0;
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        r_rd_pending   <= 1'b1;
                        r_pending_last <= (r_mem_addr == LAST_ADDR);
                        // Final address holds so the counter never passes FRAME_WORDS-1.
                        if (r_mem_addr == LAST_ADDR) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        end
                    end else begin
                        r_rd_pending   <= 1'b0;
                        r_pending_last <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    r_rd_pending   <= 1'b0;
                    r_pending_last <= 1'b0;
                    if (w_last_pop) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_mem_addr   <= {ADDR_W{1'b0}};
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_mem_addr     <= {ADDR_W{1'b0}};
                    r_rd_pending   <= 1'b0;
                    r_pending_last <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and registered non-empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != {CNT_W{1'b0}});
        end
    end

    // FIFO storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_data;
            r_fifo_last[r_wr_ptr] <= r_pending_last;
        end
    end

    assign mem_addr   = r_mem_addr;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign out_valid  = r_out_valid;
    assign out_data   = r_fifo_data[r_rd_ptr];
    // Stale tag bits in an empty FIFO must not leak out.
    assign out_last   = r_out_valid & r_fifo_last[r_rd_ptr];

endmodule

// File: doc/fb_word_fetcher.md
Name: fb_word_fetcher

Overview:
- Frame-buffer read engine that sits directly upstream of the synchronous-read test/frame memory (17-bit address, 32-bit data, registered read data).
- On a start pulse it sweeps addresses 0..FRAME_WORDS-1 and absorbs the memory's one-cycle read latency.
- Buffers the returned words in an internal FIFO and presents them to the downstream pixel pipeline over a valid/ready stream, with end-of-frame tagging.

Parameters:
- ADDR_W, 17, memory address width.
- DATA_W, 32, memory/stream word width.
- FRAME_WORDS, 115200, words per frame; range 1..2^ADDR_W.
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until frame_done.
- frame_done  out  1  one-cycle pulse when the last word is accepted downstream.
- mem_addr  out  ADDR_W  registered read address to memory.
- mem_data  in  DATA_W  memory read data; valid in the cycle after the edge that sampled mem_addr.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accept.
- out_last  out  1  head word is address FRAME_WORDS-1.

Behaviour:
- Reset (async assert, sync release) drives the following to their reset values:
  - state=IDLE, mem_addr=0, busy=0, frame_done=0, out_valid=0, out_last=0.
  - FIFO count/pointers=0, rd_pending=0.
  - FIFO storage is not reset; out_data is don't-care while out_valid=0.
- States:
  - IDLE: start=1 at an edge -> FETCH; mem_addr=0; frame_done low.
  - FETCH: an issue occurs at an edge when (fifo_count + rd_pending) < FIFO_DEPTH.
    - On issue: rd_pending<=1.
    - If mem_addr==FRAME_WORDS-1 -> DRAIN, mem_addr holds.
    - Else mem_addr<=mem_addr+1.
    - Otherwise: rd_pending<=0, mem_addr holds.
  - DRAIN: no issues; rd_pending<=0. Exit to IDLE on the edge where out_valid & out_ready & out_last.
- Capture:
  - At every edge with rd_pending=1, push {last_flag, mem_data} into the FIFO.
  - last_flag = 1 iff the issued address was FRAME_WORDS-1 (tracked in a pending_last register alongside rd_pending).
  - The space check guarantees the push never overflows.
- Pop: at an edge with out_valid & out_ready.
- Simultaneous push and pop in one cycle: count unchanged, both happen; legal at full and at empty.
  - Empty + push: out_valid rises after that edge; no combinational bypass.
- Latency: start sampled at edge E -> address 0 issued at E+1 -> captured at E+2 -> out_valid=1 during cycle after E+2.
- Throughput: with out_ready held high, one word per cycle sustained, no bubbles after the first word.
- Backpressure:
  - With out_ready=0, issues stop once count+pending reaches FIFO_DEPTH.
  - No word is dropped or duplicated; stream order equals address order.
- frame_done:
  - Registered; high for exactly the one cycle after the last-word handshake edge.
  - busy falls in that same cycle.
- start while busy: ignored, no restart.
- start in the frame_done cycle: accepted (state is IDLE).
- FRAME_WORDS=1: the single issue goes FETCH->DRAIN; the word carries out_last=1.
- Address counter never exceeds FRAME_WORDS-1; no wrap within a frame.
- rst_n asserted mid-frame: immediate return to reset values.
  - In-flight read is discarded; the FIFO is emptied.
  - The next start restarts from address 0.

Test Plan:
- Memory preloaded mem[i]=32'hA000_0000+i, FRAME_WORDS=16, out_ready=1, start pulse at edge E:
  - mem_addr=0 at E+1; out_valid first high after E+2.
  - 16 consecutive words A0000000..A000000F.
  - out_last only on A000000F; frame_done single pulse; busy low afterwards.
- Same setup, out_ready=0 for 20 cycles after start:
  - exactly FIFO_DEPTH=8 words buffered; mem_addr stalls at 8.
  - On releasing out_ready, words 0..15 emerge in order, no gaps or duplicates.
- Random out_ready (50%), FRAME_WORDS=100:
  - scoreboard sees 100 words, values A0000000..A0000063 in order.
  - FIFO never exceeds 8 entries; exactly one out_last and one frame_done.
- start re-pulsed mid-frame, then start asserted in the frame_done cycle:
  - first re-pulse ignored, stream unaffected.
  - second start accepted, second frame again begins at address 0.
- rst_n pulsed low after word 5 is accepted:
  - out_valid/busy drop immediately, mem_addr=0.
  - new start produces words from A0000000.
- FRAME_WORDS=1, out_ready=1:
  - single word A0000000 with out_last=1; frame_done one cycle later; state returns to IDLE.
